// File: rtl/bus_memory.sv
// rtl/bus_memory.sv - cache-bus main-memory responder, 32 x 16-bit lines
// Answers one read or write per request after LATENCY cycles with a bus_done pulse.
module bus_memory #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic [4:0]  bus_addr,
  input  logic [15:0] bus_din,
  output logic [15:0] bus_dout,
  output logic        bus_done,
  output logic        err,
  output logic [7:0]  rd_count,
  output logic [7:0]  wr_count
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // BUSY lasts LATENCY-1 cycles; the counter reaches zero in the last of them.
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam bit         FAST     = (LATENCY == 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        op_wr;
  logic [4:0]  addr_q;
  logic [15:0] data_q;
  logic [15:0] mem [0:31];

  logic        rd_req;
  logic        wr_req;
  logic        op_line;
  logic        commit_go;
  logic        commit_wr;
  logic [4:0]  commit_addr;
  logic [15:0] commit_data;

  // The initiator floats its request lines when idle, so only a solid 1 is a request.
  assign rd_req  = (bus_rd === 1'b1);
  assign wr_req  = (bus_wr === 1'b1);
  assign op_line = op_wr ? wr_req : rd_req;

  // The commit lands on the edge entering DONE; with LATENCY==1 that is the accept edge.
  always_comb begin
    commit_go   = 1'b0;
    commit_wr   = op_wr;
    commit_addr = addr_q;
    commit_data = data_q;
    if (FAST && state == IDLE && (rd_req ^ wr_req)) begin
      commit_go   = 1'b1;
      commit_wr   = wr_req;
      commit_addr = bus_addr;
      commit_data = bus_din;
    end else if (state == BUSY && op_line && cnt == 4'd0) begin
      commit_go = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      op_wr    <= 1'b0;
      addr_q   <= 5'd0;
      data_q   <= 16'h0000;
      bus_dout <= 16'h0000;
      bus_done <= 1'b0;
      err      <= 1'b0;
      rd_count <= 8'd0;
      wr_count <= 8'd0;
      for (int i = 0; i < 32; i++) begin
        mem[i] <= {3'b100, 5'(i), 3'b000, 5'(i)};
      end
    end else begin
      bus_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req && wr_req) begin
            err <= 1'b1;
          end else if (rd_req || wr_req) begin
            op_wr  <= wr_req;
            addr_q <= bus_addr;
            data_q <= bus_din;
            cnt    <= CNT_LOAD;
            state  <= FAST ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (!op_line) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (commit_go) begin
        bus_done <= 1'b1;
        if (commit_wr) begin
          mem[commit_addr] <= commit_data;
          if (wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
        end else begin
          bus_dout <= mem[commit_addr];
          if (rd_count != 8'hFF) rd_count <= rd_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_memory.sv
// tb/tb_bus_memory.sv - directed-vector bench for bus_memory
// Two instances share stimulus: LATENCY=4 (dut) and LATENCY=1 (dut1).
module tb_bus_memory;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_rd = 1'b0;
  logic        bus_wr = 1'b0;
  logic [4:0]  bus_addr = 5'd0;
  logic [15:0] bus_din = 16'h0000;

  logic [15:0] bus_dout, bus_dout1;
  logic        bus_done, bus_done1;
  logic        err, err1;
  logic [7:0]  rd_count, rd_count1, wr_count, wr_count1;

  int vectors = 0;
  int miscompares = 0;

  bus_memory #(.LATENCY(4)) dut (
    .clk(clk), .reset(reset), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_addr(bus_addr), .bus_din(bus_din), .bus_dout(bus_dout),
    .bus_done(bus_done), .err(err), .rd_count(rd_count), .wr_count(wr_count)
  );

  bus_memory #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_addr(bus_addr), .bus_din(bus_din), .bus_dout(bus_dout1),
    .bus_done(bus_done1), .err(err1), .rd_count(rd_count1), .wr_count(wr_count1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; bus_rd = 1'b0; bus_wr = 1'b0; bus_addr = 5'd0; bus_din = 16'h0000;
    repeat (2) next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    vectors++; if (bus_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bus_done); end
    vectors++; if (bus_dout !== 16'h0000) begin miscompares++; $display("FAIL reset_dout: got %h want 0000", bus_dout); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    vectors++; if (rd_count !== 8'd0) begin miscompares++; $display("FAIL reset_rd_count: got %0d want 0", rd_count); end
    vectors++; if (wr_count !== 8'd0) begin miscompares++; $display("FAIL reset_wr_count: got %0d want 0", wr_count); end
    vectors++; if (bus_done1 !== 1'b0) begin miscompares++; $display("FAIL reset_done1: got %b want 0", bus_done1); end
  endtask

  task automatic test_read_latency;
    do_reset();
    bus_rd = 1'b1; bus_addr = 5'd5;
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (bus_done !== (k == 4)) begin
        miscompares++; $display("FAIL read_latency_done c%0d: got %b want %b", k, bus_done, (k == 4));
      end
      if (k >= 4) begin
        vectors++;
        if (bus_dout !== 16'h8505) begin
          miscompares++; $display("FAIL read_latency_dout c%0d: got %h want 8505", k, bus_dout);
        end
      end
      if (k == 4) bus_rd = 1'b0;
      next_cycle();
    end
    vectors++; if (rd_count !== 8'd1) begin miscompares++; $display("FAIL read_latency_rd_count: got %0d want 1", rd_count); end
    vectors++; if (wr_count !== 8'd0) begin miscompares++; $display("FAIL read_latency_wr_count: got %0d want 0", wr_count); end
  endtask

  task automatic test_back_to_back;
    int first, second;
    logic [15:0] rdata;
    first = -1; second = -1; rdata = 16'h0000;
    do_reset();
    bus_wr = 1'b1; bus_addr = 5'd9; bus_din = 16'h1234;
    for (int k = 0; k < 16; k++) begin
      if (k == 2) begin
        bus_addr = 5'd10; bus_din = 16'hDEAD;
      end
      if (bus_done === 1'b1) begin
        if (first < 0) begin
          first = k; bus_wr = 1'b0; bus_rd = 1'b1; bus_addr = 5'd9;
        end else if (second < 0) begin
          second = k; rdata = bus_dout; bus_rd = 1'b0;
        end
      end
      next_cycle();
    end
    vectors++; if (first != 4) begin miscompares++; $display("FAIL b2b_first_done: got %0d want 4", first); end
    vectors++; if (second != 9) begin miscompares++; $display("FAIL b2b_second_done: got %0d want 9", second); end
    vectors++; if (rdata !== 16'h1234) begin miscompares++; $display("FAIL b2b_read_data: got %h want 1234", rdata); end
    vectors++; if (wr_count !== 8'd1) begin miscompares++; $display("FAIL b2b_wr_count: got %0d want 1", wr_count); end
    vectors++; if (rd_count !== 8'd1) begin miscompares++; $display("FAIL b2b_rd_count: got %0d want 1", rd_count); end
  endtask

  task automatic test_abort;
    logic seen;
    int got;
    logic [15:0] rdata;
    seen = 1'b0; got = 0; rdata = 16'h0000;
    do_reset();
    bus_wr = 1'b1; bus_addr = 5'd3; bus_din = 16'hFFFF;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) bus_wr = 1'b0;
      if (bus_done === 1'b1) seen = 1'b1;
      next_cycle();
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL abort_no_done: got %b want 0", seen); end
    bus_rd = 1'b1; bus_addr = 5'd3;
    for (int k = 0; k < 12; k++) begin
      if (bus_done === 1'b1 && got == 0) begin
        got = 1; rdata = bus_dout; bus_rd = 1'b0;
      end
      next_cycle();
    end
    bus_rd = 1'b0;
    vectors++; if (got != 1) begin miscompares++; $display("FAIL abort_read_done: got %0d want 1", got); end
    vectors++; if (rdata !== 16'h8303) begin miscompares++; $display("FAIL abort_read_data: got %h want 8303", rdata); end
    vectors++; if (wr_count !== 8'd0) begin miscompares++; $display("FAIL abort_wr_count: got %0d want 0", wr_count); end
    vectors++; if (rd_count !== 8'd1) begin miscompares++; $display("FAIL abort_rd_count: got %0d want 1", rd_count); end
  endtask

  task automatic test_illegal;
    logic seen;
    seen = 1'b0;
    do_reset();
    bus_rd = 1'b1; bus_wr = 1'b1; bus_addr = 5'd4;
    for (int k = 0; k < 5; k++) begin
      if (bus_done === 1'b1) seen = 1'b1;
      next_cycle();
    end
    bus_rd = 1'b0; bus_wr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (bus_done === 1'b1) seen = 1'b1;
      next_cycle();
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL illegal_no_done: got %b want 0", seen); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL illegal_err_sticky: got %b want 1", err); end
    vectors++; if (rd_count !== 8'd0 || wr_count !== 8'd0) begin
      miscompares++; $display("FAIL illegal_counts: got %0d/%0d want 0/0", rd_count, wr_count);
    end
    do_reset();
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL illegal_err_reset: got %b want 0", err); end
  endtask

  task automatic test_floating;
    logic seen;
    seen = 1'b0;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      bus_rd = (k % 2 == 0) ? 1'bz : 1'bx;
      bus_wr = (k % 2 == 0) ? 1'bx : 1'bz;
      bus_addr = 5'(k);
      if (bus_done === 1'b1) seen = 1'b1;
      next_cycle();
    end
    bus_rd = 1'b0; bus_wr = 1'b0;
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL floating_no_done: got %b want 0", seen); end
    vectors++; if (rd_count !== 8'd0 || wr_count !== 8'd0) begin
      miscompares++; $display("FAIL floating_counts: got %0d/%0d want 0/0", rd_count, wr_count);
    end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL floating_err: got %b want 0", err); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    int got;
    logic [15:0] rdata;
    seen = 1'b0; got = 0; rdata = 16'h0000;
    do_reset();
    bus_wr = 1'b1; bus_addr = 5'd7; bus_din = 16'hBEEF;
    for (int k = 0; k < 10; k++) begin
      if (k == 2) begin
        reset = 1'b1; bus_wr = 1'b0;
      end
      if (k == 3) reset = 1'b0;
      if (bus_done === 1'b1) seen = 1'b1;
      next_cycle();
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL reset_mid_no_done: got %b want 0", seen); end
    bus_rd = 1'b1; bus_addr = 5'd7;
    for (int k = 0; k < 12; k++) begin
      if (bus_done === 1'b1 && got == 0) begin
        got = 1; rdata = bus_dout; bus_rd = 1'b0;
      end
      next_cycle();
    end
    bus_rd = 1'b0;
    vectors++; if (rdata !== 16'h8707) begin miscompares++; $display("FAIL reset_mid_mem7: got %h want 8707", rdata); end
    vectors++; if (wr_count !== 8'd0) begin miscompares++; $display("FAIL reset_mid_wr_count: got %0d want 0", wr_count); end
  endtask

  task automatic test_latency1;
    do_reset();
    bus_rd = 1'b1; bus_addr = 5'd10;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (bus_done1 !== (k == 1)) begin
        miscompares++; $display("FAIL lat1_done c%0d: got %b want %b", k, bus_done1, (k == 1));
      end
      if (k == 1) begin
        vectors++;
        if (bus_dout1 !== 16'h8A0A) begin miscompares++; $display("FAIL lat1_dout: got %h want 8a0a", bus_dout1); end
        bus_rd = 1'b0;
      end
      next_cycle();
    end
    vectors++; if (rd_count1 !== 8'd1) begin miscompares++; $display("FAIL lat1_rd_count: got %0d want 1", rd_count1); end
  endtask

  task automatic test_saturation;
    do_reset();
    bus_rd = 1'b1; bus_addr = 5'd1;
    repeat (600) next_cycle();
    bus_rd = 1'b0;
    vectors++; if (rd_count1 !== 8'd255) begin miscompares++; $display("FAIL sat_rd_count1: got %0d want 255", rd_count1); end
    vectors++; if (rd_count !== 8'd120) begin miscompares++; $display("FAIL sat_rd_count: got %0d want 120", rd_count); end
    vectors++; if (bus_dout1 !== 16'h8101) begin miscompares++; $display("FAIL sat_dout1: got %h want 8101", bus_dout1); end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_back_to_back();
    test_abort();
    test_illegal();
    test_floating();
    test_reset_mid();
    test_latency1();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_memory.md
# bus_memory

Main-memory responder for the cache bus: the target end of the `bus_rd`/`bus_wr`/`bus_addr`/`bus_done` handshake driven by the cache controller. Holds 32 lines of 16 bits, one line per 5-bit bus address. Answers each accepted read or write after a programmable latency with a one-cycle `bus_done` pulse. Used as the memory model in cache benches and as the backing-store block in the top-level integration.

## Interface
- `LATENCY`, 4: cycles from request acceptance to `bus_done`; legal range 1–15.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `bus_rd` in 1: read request, level-held by the initiator until `bus_done`.
- `bus_wr` in 1: write request, level-held by the initiator until `bus_done`.
- `bus_addr` in 5: line address.
- `bus_din` in 16: write data, connected to the cache's `bus_dout`.
- `bus_dout` out 16: read data, connected to the cache's `bus_din`.
- `bus_done` out 1: completion pulse, connected to the cache's `bus_done`.
- `err` out 1: sticky protocol-error flag.
- `rd_count` out 8: completed reads, saturating.
- `wr_count` out 8: completed writes, saturating.

## Operation
- Storage: `mem[0:31]`, 16 bits each. Reset loads `mem[a] = {8'h80 | a, 8'h00 | a}`, e.g. `mem[5] = 16'h8505`.
- Request decode: only a value of exactly 1 counts as asserted. 0, X and Z all mean no request. The initiator floats these lines while idle.
- FSM states:
  - IDLE:
    - Exactly one of `bus_rd`/`bus_wr` is 1: accept. Capture the op, `bus_addr` and `bus_din`. Load the latency counter. Go to BUSY, or go directly to DONE if `LATENCY==1`.
    - Both are 1: do not accept. Set `err`. Stay in IDLE.
  - BUSY:
    - Decrement the counter each cycle.
    - When the count expires, go to DONE.
    - The captured op's line must stay asserted. If it is sampled not-1, abort: go to IDLE, no commit, no `bus_done`, counters unchanged.
  - DONE:
    - `bus_done=1` for this cycle only. Return to IDLE unconditionally.
- Commit happens on the edge that enters DONE:
  - Write: `mem[addr] <= data`, and `wr_count` increments.
  - Read: `bus_dout <= mem[addr]`, and `rd_count` increments.
- `bus_dout` holds its value until the next completed read. It is not cleared by writes or aborts.
- Counters saturate at 255.
- `err` clears only on reset.
- Captured address and data are used for the commit. Input changes after acceptance are ignored.

## Timing
- Reset values: `bus_done=0`, `bus_dout=16'h0000`, `err=0`, `rd_count=0`, `wr_count=0`, FSM in IDLE. Memory array reinitialized to the pattern above.
- Reset asserted in any state, including mid-BUSY:
  - Return to IDLE next cycle.
  - Any in-flight write is dropped.
  - No `bus_done` is issued.
- Latency: let cycle c be the first cycle a valid request is sampled in IDLE. `bus_done` is high in cycle c+LATENCY only.
- Read data is valid on `bus_dout` in the same cycle as `bus_done`.
- `bus_done` is never high for two consecutive cycles.
- Minimum turnaround:
  - The initiator deasserts or switches its request on the edge that samples `bus_done`.
  - Memory is back in IDLE at that same edge and samples a new request the following cycle.
  - A write-back immediately followed by a fetch is therefore accepted without a gap. Second acceptance cycle = first `bus_done` cycle + 1.
- Read-after-write to the same address returns the new data, because the commit happens before the next acceptance.

## Test plan
- Reset, then `LATENCY=4`, hold `bus_rd=1` with `bus_addr=5` starting at cycle 0 → `bus_done` high in cycle 4 only; `bus_dout=16'h8505` in cycle 4 and held afterward; `rd_count=1`.
- Write then read, back-to-back:
  - Stimulus: `bus_wr=1`, addr 9, data `16'h1234` until `bus_done`; switch to `bus_rd=1`, addr 9, on the next cycle.
  - Response: two `bus_done` pulses, 5 cycles apart; read returns `16'h1234`; `wr_count=1`, `rd_count=1`.
- Abort: `bus_wr=1`, addr 3, data `16'hFFFF`, held 2 cycles then 0 → no `bus_done`. A subsequent read of addr 3 returns `16'h8303`; `wr_count=0`.
- Illegal request: `bus_rd=1` and `bus_wr=1` together in IDLE → no `bus_done`, `err=1` and held. After reset, `err=0`.
- Floating lines: `bus_rd`/`bus_wr` driven Z or X for 20 cycles → no `bus_done`, counters 0, `err=0`.
- Reset mid-operation: reset asserted in cycle 2 of a write to addr 7 → no `bus_done`; `mem[7]` reads back `16'h8707`. Also run with `LATENCY=1`: `bus_done` is high the cycle after the request is first seen.
